// File: rtl/btn_debounce_pulse_if.sv
// Button bus between the board pins and the debounce block: raw levels in,
// debounced levels and one-cycle capture strobes out.
interface btn_debounce_pulse_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] i_btn;
    logic [N_BTN-1:0] o_level;
    logic [N_BTN-1:0] o_pulse;

    modport master (output i_btn, input o_level, input o_pulse);
    modport slave  (input i_btn, output o_level, output o_pulse);
endinterface

// File: rtl/btn_debounce_pulse.sv
// Per-button synchronizer + counter debounce FSM + registered edge strobe.
// Define BTN_PULSE_ON_RELEASE_EN to strobe on accepted releases instead of presses.
module btn_debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NB_CNT          = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic pulse
);
    typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;

    localparam logic [NB_CNT-1:0] LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_PULSE_ON_RELEASE_EN
    localparam logic PULSE_RISE = 1'b0;
    localparam logic PULSE_FALL = 1'b1;
`else
    localparam logic PULSE_RISE = 1'b1;
    localparam logic PULSE_FALL = 1'b0;
`endif

    logic              sync1, sync2;
    state_t            state, state_nxt;
    logic [NB_CNT-1:0] cnt, cnt_nxt;
    logic              level_nxt, pulse_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= IDLE_LOW;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            pulse <= pulse_nxt;
        end
    end

    // cnt counts edges already seen at the new level; acceptance on the
    // DEBOUNCE_CYCLES-th one, so cnt never passes LAST.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        pulse_nxt = 1'b0;
        unique case (state)
            IDLE_LOW: begin
                if (sync2) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = NB_CNT'(1);
                end
            end
            WAIT_HIGH: begin
                if (!sync2) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    pulse_nxt = PULSE_RISE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!sync2) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = NB_CNT'(1);
                end
            end
            WAIT_LOW: begin
                if (sync2) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    pulse_nxt = PULSE_FALL;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end
endmodule

module btn_debounce_pulse #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NB_CNT          = 20
) (
    input logic                  clk,
    input logic                  reset,
    btn_debounce_pulse_if.slave  bus
);
    logic [N_BTN-1:0] level, pulse;

    for (genvar k = 0; k < N_BTN; k++) begin : g_chan
        btn_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .NB_CNT          (NB_CNT)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .btn   (bus.i_btn[k]),
            .level (level[k]),
            .pulse (pulse[k])
        );
    end

    assign bus.o_level = level;
    assign bus.o_pulse = pulse;
endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with DEBOUNCE_CYCLES=4, NB_CNT=3.
module tb_btn_debounce_pulse;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

`ifdef BTN_PULSE_ON_RELEASE_EN
    localparam bit ON_REL = 1'b1;
`else
    localparam bit ON_REL = 1'b0;
`endif

    btn_debounce_pulse_if #(.N_BTN(3)) bus ();

    btn_debounce_pulse #(
        .N_BTN           (3),
        .DEBOUNCE_CYCLES (4),
        .NB_CNT          (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic edge_tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] pexp;
        bus.i_btn = 3'b000;

        // async reset before any clock edge
        #5 reset = 1'b1;
        #1;
        check("rst_level", bus.o_level, 3'b000);
        check("rst_pulse", bus.o_pulse, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // clean press on channel 0
        bus.i_btn = 3'b001;
        for (int e = 1; e <= 7; e++) begin
            edge_tick();
            pexp = (!ON_REL && e == 6) ? 3'b001 : 3'b000;
            check($sformatf("press_lvl_e%0d", e), bus.o_level, (e >= 6) ? 3'b001 : 3'b000);
            check($sformatf("press_pls_e%0d", e), bus.o_pulse, pexp);
        end

        // bounce on channel 1: raw 1,1,0 then held 1; final rise sampled at k=3
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            bus.i_btn[1] = (k == 2) ? 1'b0 : 1'b1;
            edge_tick();
            pexp = (!ON_REL && k == 8) ? 3'b010 : 3'b000;
            check($sformatf("bounce_lvl_k%0d", k), bus.o_level, (k >= 8) ? 3'b011 : 3'b001);
            check($sformatf("bounce_pls_k%0d", k), bus.o_pulse, pexp);
        end

        // short glitch on channel 2: three cycles high never qualifies
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            bus.i_btn[2] = (k < 3);
            edge_tick();
            check($sformatf("glitch_lvl_k%0d", k), bus.o_level, 3'b011);
            check($sformatf("glitch_pls_k%0d", k), bus.o_pulse, 3'b000);
        end

        // release channel 0
        @(negedge clk) bus.i_btn[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            edge_tick();
            pexp = (ON_REL && e == 6) ? 3'b001 : 3'b000;
            check($sformatf("rel_lvl_e%0d", e), bus.o_level, (e >= 6) ? 3'b010 : 3'b011);
            check($sformatf("rel_pls_e%0d", e), bus.o_pulse, pexp);
        end

        // reset in the middle of a pending press on channel 0
        @(negedge clk) bus.i_btn = 3'b001;
        for (int e = 1; e <= 4; e++) begin
            edge_tick();
            check($sformatf("mid_pls_e%0d", e), bus.o_pulse, 3'b000);
            check($sformatf("mid_lvl0_e%0d", e), {2'b00, bus.o_level[0]}, 3'b000);
        end
        reset = 1'b1;
        #1;
        check("mid_rst_level", bus.o_level, 3'b000);
        check("mid_rst_pulse", bus.o_pulse, 3'b000);
        @(negedge clk) reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            edge_tick();
            pexp = (!ON_REL && e == 6) ? 3'b001 : 3'b000;
            check($sformatf("post_lvl_e%0d", e), bus.o_level, (e >= 6) ? 3'b001 : 3'b000);
            check($sformatf("post_pls_e%0d", e), bus.o_pulse, pexp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
